// File: rtl/snn_input_packet_fifo.sv
// snn_input_packet_fifo
//   Packet input buffer feeding the west input of the RANC network grid.
//   Host/DMA side writes opaque spike packets through a valid/ready port.
//   The grid reads them using its empty/ren handshake. The block also
//   reports occupancy, almost-full back-pressure, flush and sticky
//   overflow/underflow error flags to the SoC CSR block.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   wr_valid, wr_data : host packet in; wr_ready = !full
//   ren               : pop request from the grid (ren_to_input_buffer)
//   empty             : to grid input_buffer_empty
//   packet_out        : head entry to grid packet_in (zero while empty)
//   full, almost_full : status decoded from the registered count
//   count             : current occupancy
//   flush             : discard all entries
//   error_clear       : clear the sticky error flags
//   overflow_error    : sticky, set when a write is attempted while full
//   underflow_error   : sticky, set when ren is asserted while empty
module snn_input_packet_fifo #(
  parameter int PACKET_WIDTH       = 30,
  parameter int DEPTH              = 64,
  parameter int ALMOST_FULL_THRESH = 60
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [PACKET_WIDTH-1:0]    wr_data,
  output logic                       wr_ready,
  input  logic                       ren,
  output logic                       empty,
  output logic [PACKET_WIDTH-1:0]    packet_out,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       flush,
  input  logic                       error_clear,
  output logic                       overflow_error,
  output logic                       underflow_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  logic empty_s, full_s;
  logic wr_en_s, rd_en_s;
  logic ovf_event_s, unf_event_s;

  // Status flags come only from the registered count, so the grid and host
  // never see a combinational path from their own inputs back to them.
  always_comb begin
    empty_s     = (count_q == {CW{1'b0}});
    full_s      = (count_q == CW'(DEPTH));
    empty       = empty_s;
    full        = full_s;
    wr_ready    = ~full_s;
    almost_full = (count_q >= CW'(ALMOST_FULL_THRESH));
    count       = count_q;
  end

  // Accepted write/pop and error events; no bypass through a same-cycle pop
  // or write, and everything is ignored while reset is high.
  always_comb begin
    wr_en_s     = wr_valid & ~full_s & ~reset;
    rd_en_s     = ren & ~empty_s & ~reset;
    ovf_event_s = wr_valid & full_s;
    unf_event_s = ren & empty_s;
  end

  // Pointer and occupancy next state; flush overrides any write or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky error flags: a new event in the clear cycle wins over the clear.
  always_comb begin
    if (ovf_event_s) begin
      ovf_d = 1'b1;
    end else if (error_clear) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (unf_event_s) begin
      unf_d = 1'b1;
    end else if (error_clear) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Packet storage; left unreset since count gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_en_s && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Head presentation and error flag outputs.
  always_comb begin
    if (empty_s) begin
      packet_out = {PACKET_WIDTH{1'b0}};
    end else begin
      packet_out = mem_q[rd_ptr_q];
    end
    overflow_error  = ovf_q;
    underflow_error = unf_q;
  end

endmodule

// File: tb/tb_snn_input_packet_fifo.sv
module tb_snn_input_packet_fifo;

  localparam int PW    = 30;
  localparam int DEPTH = 64;
  localparam int THR   = 60;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [PW-1:0] wr_data;
  logic          wr_ready;
  logic          ren;
  logic          empty;
  logic [PW-1:0] packet_out;
  logic          full;
  logic          almost_full;
  logic [6:0]    count;
  logic          flush;
  logic          error_clear;
  logic          overflow_error;
  logic          underflow_error;

  always #5 clk = ~clk;

  snn_input_packet_fifo #(
    .PACKET_WIDTH(PW), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(THR)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .ren(ren), .empty(empty), .packet_out(packet_out),
    .full(full), .almost_full(almost_full), .count(count), .flush(flush),
    .error_clear(error_clear), .overflow_error(overflow_error),
    .underflow_error(underflow_error)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model: queue of stored packets plus two sticky flags.
  logic [PW-1:0] sb[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare DUT state against the model, then advance the model
  // with the inputs that the coming clock edge will sample.
  initial begin
    int n;
    bit ovf_ev, unf_ev;
    logic [PW-1:0] exp_pkt;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n = sb.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= THR));
        chk("wr_ready", 32'(wr_ready), 32'(n != DEPTH));
        chk("overflow_error", 32'(overflow_error), 32'(m_ovf));
        chk("underflow_error", 32'(underflow_error), 32'(m_unf));
        chk("packet_out", 32'(packet_out), (n > 0) ? 32'(sb[0]) : 32'd0);
        if (reset) begin
          sb.delete();
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end else begin
          ovf_ev = wr_valid && (n == DEPTH);
          unf_ev = ren && (n == 0);
          if (ren && n > 0 && !flush) begin
            exp_pkt = sb.pop_front();
            chk("pop_data", 32'(packet_out), 32'(exp_pkt));
          end
          if (flush) sb.delete();
          else if (wr_valid && n < DEPTH) sb.push_back(wr_data);
          m_ovf = ovf_ev ? 1'b1 : (error_clear ? 1'b0 : m_ovf);
          m_unf = unf_ev ? 1'b1 : (error_clear ? 1'b0 : m_unf);
        end
      end
    end
  end

  task automatic drive(input bit wv, input logic [PW-1:0] wd, input bit r,
                       input bit fl, input bit ec, input bit rs);
    wr_valid    = wv;
    wr_data     = wd;
    ren         = r;
    flush       = fl;
    error_clear = ec;
    reset       = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [31:0] v;
    v = $urandom;
    return v[PW-1:0];
  endfunction

  initial begin
    int pw, pr;
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; ren = 1'b0;
    flush = 1'b0; error_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Three writes, then three pops in order.
    for (int i = 1; i <= 3; i++) drive(1'b1, PW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill to full, then an extra write that must be dropped.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, PW'(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 30'h3FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full with write and pop together: pop only; then clear errors.
    drive(1'b1, 30'h2AAA_AAAA, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Drain past empty to raise underflow, clear, then ren plus write on empty.
    for (int i = 0; i < 64; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 30'h155, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reach count 5 and stream 200 cycles of simultaneous write/pop.
    for (int i = 0; i < 4; i++) drive(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) drive(1'b1, rnd_pkt(), 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush to empty, raise underflow, refill to 10, flush with write+ren.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, rnd_pkt(), 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Refill, then reset mid-stream with a write and pop pending.
    for (int i = 0; i < 10; i++) drive(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, rnd_pkt(), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized phases with varying write/pop pressure.
    for (int ph = 0; ph < 10; ph++) begin
      pw = $urandom_range(90, 10);
      pr = $urandom_range(90, 10);
      for (int c = 0; c < 300; c++) begin
        drive($urandom_range(99, 0) < pw, rnd_pkt(), $urandom_range(99, 0) < pr,
              $urandom_range(99, 0) == 0, $urandom_range(19, 0) == 0,
              $urandom_range(499, 0) == 0);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
